// File: rtl/pipe_control_unit_if.sv
// Bus between the 5-stage pipeline datapath and its control unit:
// ID-stage instruction fields in, per-stage control bundles out.
interface pipe_control_unit_if #(
    parameter int ALU_CTRL_W = 3,
    parameter int REG_ADDR_W = 5
);
    logic [5:0]            op_code_id;
    logic [5:0]            funct_id;
    logic [REG_ADDR_W-1:0] rs_id;
    logic [REG_ADDR_W-1:0] rt_id;
    logic [REG_ADDR_W-1:0] rd_id;
    logic                  branch_taken_ex;

    logic                  jump_id;
    logic                  illegal_id;
    logic                  stall_o;

    logic                  alu_src_ex;
    logic                  mem_read_ex;
    logic                  branch_ex;
    logic                  bne_ex;
    logic [ALU_CTRL_W-1:0] alu_ctrl_ex;
    logic                  reg_write_ex;
    logic [REG_ADDR_W-1:0] wr_reg_ex;

    logic                  mem_read_mem;
    logic                  mem_write_mem;
    logic                  reg_write_mem;
    logic [REG_ADDR_W-1:0] wr_reg_mem;

    logic                  reg_write_wb;
    logic                  mem_to_reg_wb;
    logic [REG_ADDR_W-1:0] wr_reg_wb;

    // Datapath side: presents the ID instruction, consumes controls.
    modport master (
        output op_code_id, funct_id, rs_id, rt_id, rd_id, branch_taken_ex,
        input  jump_id, illegal_id, stall_o,
        input  alu_src_ex, mem_read_ex, branch_ex, bne_ex, alu_ctrl_ex,
        input  reg_write_ex, wr_reg_ex,
        input  mem_read_mem, mem_write_mem, reg_write_mem, wr_reg_mem,
        input  reg_write_wb, mem_to_reg_wb, wr_reg_wb
    );

    // Control-unit side.
    modport slave (
        input  op_code_id, funct_id, rs_id, rt_id, rd_id, branch_taken_ex,
        output jump_id, illegal_id, stall_o,
        output alu_src_ex, mem_read_ex, branch_ex, bne_ex, alu_ctrl_ex,
        output reg_write_ex, wr_reg_ex,
        output mem_read_mem, mem_write_mem, reg_write_mem, wr_reg_mem,
        output reg_write_wb, mem_to_reg_wb, wr_reg_wb
    );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control unit: ID decode, ID/EX, EX/MEM, MEM/WB control
// registers, load-use stall detection and bubble insertion on stall/flush.
module pipe_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter int EXT_ISA    = 1,
    parameter int REG_ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_control_unit_if.slave bus
);

    if (ALU_CTRL_W < 3) begin : g_alu_w_check
        $error("pipe_control_unit: ALU_CTRL_W must be at least 3");
    end

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_MUL = 6'b011100;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;

    localparam logic [2:0] A_AND = 3'b000;
    localparam logic [2:0] A_OR  = 3'b001;
    localparam logic [2:0] A_ADD = 3'b010;
    localparam logic [2:0] A_SUB = 3'b100;
    localparam logic [2:0] A_MUL = 3'b101;
    localparam logic [2:0] A_SLT = 3'b110;
    localparam logic [2:0] A_BAD = 3'b111;

    typedef struct packed {
        logic                  alu_src;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  branch;
        logic                  bne;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic [REG_ADDR_W-1:0] wr_reg;
    } ex_ctrl_t;

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] wr_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] wr_reg;
    } wb_ctrl_t;

    function automatic logic [ALU_CTRL_W-1:0] alu_code(input logic [2:0] c);
        return ALU_CTRL_W'(c);
    endfunction

    function automatic ex_ctrl_t bubble_bundle();
        ex_ctrl_t b;
        b          = '0;
        b.alu_ctrl = alu_code(A_ADD);
        return b;
    endfunction

    ex_ctrl_t  dec;
    logic      jump_dec;
    logic      illegal_dec;
    logic      stall;
    ex_ctrl_t  ex_d, ex_q;
    mem_ctrl_t mem_d, mem_q;
    wb_ctrl_t  wb_d, wb_q;

    // Anything that is not a recognised encoding falls out as a bubble.
    always_comb begin
        dec         = bubble_bundle();
        jump_dec    = 1'b0;
        illegal_dec = 1'b0;
        case (bus.op_code_id)
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                dec.wr_reg    = bus.rd_id;
                case (bus.funct_id)
                    F_ADD:   dec.alu_ctrl = alu_code(A_ADD);
                    F_SUB:   dec.alu_ctrl = alu_code(A_SUB);
                    F_SLT:   dec.alu_ctrl = alu_code(A_SLT);
                    F_MUL:   dec.alu_ctrl = alu_code(A_MUL);
                    F_AND:   dec.alu_ctrl = alu_code(A_AND);
                    F_OR:    dec.alu_ctrl = alu_code(A_OR);
                    default: begin
                        dec.alu_ctrl  = alu_code(A_BAD);
                        dec.reg_write = 1'b0;
                        illegal_dec   = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.wr_reg     = bus.rt_id;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.wr_reg    = bus.rt_id;
            end
            OP_BEQ: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = alu_code(A_SUB);
            end
            OP_J: jump_dec = 1'b1;
            OP_ANDI, OP_ORI, OP_SLTI: begin
                if (EXT_ISA != 0) begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.wr_reg    = bus.rt_id;
                    if (bus.op_code_id == OP_ANDI)
                        dec.alu_ctrl = alu_code(A_AND);
                    else if (bus.op_code_id == OP_ORI)
                        dec.alu_ctrl = alu_code(A_OR);
                    else
                        dec.alu_ctrl = alu_code(A_SLT);
                end else begin
                    illegal_dec = 1'b1;
                end
            end
            OP_BNE: begin
                if (EXT_ISA != 0) begin
                    dec.branch   = 1'b1;
                    dec.bne      = 1'b1;
                    dec.alu_ctrl = alu_code(A_SUB);
                end else begin
                    illegal_dec = 1'b1;
                end
            end
            default: illegal_dec = 1'b1;
        endcase
    end

    // rt is compared for every opcode; a spurious stall only costs a cycle.
    assign stall = ex_q.mem_read & ex_q.reg_write & (ex_q.wr_reg != '0) &
                   ((ex_q.wr_reg == bus.rs_id) | (ex_q.wr_reg == bus.rt_id));

    always_comb begin
        ex_d = (stall | bus.branch_taken_ex) ? bubble_bundle() : dec;

        mem_d.mem_read   = ex_q.mem_read;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.mem_to_reg = ex_q.mem_to_reg;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.wr_reg     = ex_q.wr_reg;

        wb_d.mem_to_reg  = mem_q.mem_to_reg;
        wb_d.reg_write   = mem_q.reg_write;
        wb_d.wr_reg      = mem_q.wr_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= bubble_bundle();
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign bus.jump_id       = jump_dec;
    assign bus.illegal_id    = illegal_dec;
    assign bus.stall_o       = stall;

    assign bus.alu_src_ex    = ex_q.alu_src;
    assign bus.mem_read_ex   = ex_q.mem_read;
    assign bus.branch_ex     = ex_q.branch;
    assign bus.bne_ex        = ex_q.bne;
    assign bus.alu_ctrl_ex   = ex_q.alu_ctrl;
    assign bus.reg_write_ex  = ex_q.reg_write;
    assign bus.wr_reg_ex     = ex_q.wr_reg;

    assign bus.mem_read_mem  = mem_q.mem_read;
    assign bus.mem_write_mem = mem_q.mem_write;
    assign bus.reg_write_mem = mem_q.reg_write;
    assign bus.wr_reg_mem    = mem_q.wr_reg;

    assign bus.reg_write_wb  = wb_q.reg_write;
    assign bus.mem_to_reg_wb = wb_q.mem_to_reg;
    assign bus.wr_reg_wb     = wb_q.wr_reg;

endmodule
